// File: rtl/sync_memory_dp_if.sv
// sync_memory_dp_if -- bus bundle for the dual-port synchronous memory.
//
// Ports carried (direction as seen by the memory, i.e. the slave modport):
//   data_in      in   DATA_WIDTH    write data
//   write_enable in   1             write request
//   byte_en      in   DATA_WIDTH/8  per-byte write mask (bit i -> data_in[8i+7:8i])
//   wr_addr      in   ADDR_WIDTH    write address
//   read_enable  in   1             read request
//   rd_addr      in   ADDR_WIDTH    read address
//   clear_req    in   1             single-cycle request to zero the array
//   data_out     out  DATA_WIDTH    registered read data
//   rd_valid     out  1             one-cycle pulse marking data_out as new
//   busy         out  1             high while a clear is in progress
interface sync_memory_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   data_in;
    logic                    write_enable;
    logic [DATA_WIDTH/8-1:0] byte_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    read_enable;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    clear_req;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    rd_valid;
    logic                    busy;

    modport master (
        output data_in, write_enable, byte_en, wr_addr,
        output read_enable, rd_addr, clear_req,
        input  data_out, rd_valid, busy
    );

    modport slave (
        input  data_in, write_enable, byte_en, wr_addr,
        input  read_enable, rd_addr, clear_req,
        output data_out, rd_valid, busy
    );
endinterface

// File: rtl/sync_memory_dp.sv
// sync_memory_dp -- single-clock memory with one byte-masked write port,
// one registered read port (latency 1 or 2) and a self-clearing sequence
// that zeroes the whole array after reset or on clear_req.
//
// Ports:
//   clk  in  single clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  sync_memory_dp_if.slave (write/read/clear requests, data_out,
//        rd_valid, busy)
//
// Build option: macro SYNC_MEM_BYPASS_EN selects write-first behaviour for
// a same-cycle read and write to one address; undefined gives read-first.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zeroing address clr_cnt each cycle; bus requests ignored
// ST_READY | normal operation; reads and writes accepted
module sync_memory_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1
) (
    input logic             clk,
    input logic             rst,
    sync_memory_dp_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    pipe_valid_q, pipe_valid_d;
    logic [DATA_WIDTH-1:0]   pipe_data_q, pipe_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    wr_in_range, rd_in_range;
    logic                    wr_fire, rd_fire;
    logic [NB-1:0]           mem_be;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   rd_old, rd_word, out_src;

    // Control FSM and clear counter
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (bus.clear_req) state_d = ST_CLEAR;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // Write port: the clear sequence and bus writes share one array port
    always_comb begin
        wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_L);
        wr_fire     = (state_q == ST_READY) && bus.write_enable && wr_in_range;
        if (state_q == ST_CLEAR) begin
            mem_be    = '1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
        end else begin
            mem_be    = wr_fire ? bus.byte_en : '0;
            mem_waddr = bus.wr_addr;
            mem_wdata = bus.data_in;
        end
        // The array is never touched while reset is held; zeroing happens
        // only through the clear sequence that follows release.
        if (rst) mem_be = '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_be[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    // Read port
    always_comb begin
        rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_L);
        rd_fire     = (state_q == ST_READY) && bus.read_enable;
        rd_old      = rd_in_range ? mem_q[bus.rd_addr] : '0;
        rd_word     = rd_old;
`ifdef SYNC_MEM_BYPASS_EN
        // Write-first: overlay the bytes being written this cycle.
        if (wr_fire && (bus.wr_addr == bus.rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.byte_en[i]) rd_word[8*i +: 8] = bus.data_in[8*i +: 8];
            end
        end
`else
        // Read-first: the array updates on the same edge, so rd_old is
        // already the pre-write word.
`endif
    end

    // Read pipeline; keeps draining regardless of FSM state
    always_comb begin
        pipe_valid_d = rd_fire;
        pipe_data_d  = rd_fire ? rd_word : pipe_data_q;
        if (RD_LATENCY == 2) begin
            rd_valid_d = pipe_valid_q;
            out_src    = pipe_data_q;
        end else begin
            rd_valid_d = rd_fire;
            out_src    = rd_word;
        end
        data_out_d = rd_valid_d ? out_src : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLEAR;
            clr_cnt_q    <= '0;
            pipe_valid_q <= 1'b0;
            pipe_data_q  <= '0;
            rd_valid_q   <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_data_q  <= pipe_data_d;
            rd_valid_q   <= rd_valid_d;
            data_out_q   <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_sync_memory_dp.sv
// tb_sync_memory_dp -- directed bench for sync_memory_dp.
// dut_a: DEPTH=256, RD_LATENCY=1.  dut_b: DEPTH=200, RD_LATENCY=2.
// Both share the stimulus signals; each has its own reset, and the one not
// under test is held in reset.
module tb_sync_memory_dp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [31:0] data_in;
    logic        we, re, clr;
    logic [3:0]  be;
    logic [7:0]  wa, ra;
    bit          sel;

    int n_chk = 0;
    int n_err = 0;

    sync_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_a ();
    sync_memory_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_b ();

    assign bus_a.data_in      = data_in;
    assign bus_a.write_enable = we;
    assign bus_a.byte_en      = be;
    assign bus_a.wr_addr      = wa;
    assign bus_a.read_enable  = re;
    assign bus_a.rd_addr      = ra;
    assign bus_a.clear_req    = clr;
    assign bus_b.data_in      = data_in;
    assign bus_b.write_enable = we;
    assign bus_b.byte_en      = be;
    assign bus_b.wr_addr      = wa;
    assign bus_b.read_enable  = re;
    assign bus_b.rd_addr      = ra;
    assign bus_b.clear_req    = clr;

    sync_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .RD_LATENCY(1))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    sync_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .RD_LATENCY(2))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    logic [31:0] dout;
    logic        vld, bsy;
    always_comb begin
        dout = sel ? bus_b.data_out : bus_a.data_out;
        vld  = sel ? bus_b.rd_valid : bus_a.rd_valid;
        bsy  = sel ? bus_b.busy     : bus_a.busy;
    end

    task automatic chk_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [7:0] addr, logic [31:0] data, logic [3:0] mask);
        we = 1'b1; wa = addr; data_in = data; be = mask;
        step();
        we = 1'b0; be = 4'h0;
    endtask

    task automatic rd_chk(string tag, logic [7:0] addr, logic [31:0] exp, int exp_lat);
        int lat;
        re = 1'b1; ra = addr;
        step();
        re = 1'b0;
        lat = 1;
        while (!vld && lat < 8) begin
            step();
            lat++;
        end
        chk_eq({tag, "_lat"}, lat, exp_lat);
        chk_eq(tag, dout, exp);
    endtask

    task automatic busy_len(string tag, int exp);
        int n;
        n = 0;
        while (bsy && n < 1000) begin
            step();
            n++;
        end
        chk_eq(tag, n, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_col, held;
        int n, pulses;
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
        data_in = '0; we = 1'b0; re = 1'b0; clr = 1'b0; be = 4'h0; wa = '0; ra = '0;

        // ---------------- dut_a: DEPTH=256, latency 1 ----------------
        step(); step();
        chk_eq("a_rst_busy", bsy, 1'b1);
        chk_eq("a_rst_vld",  vld, 1'b0);
        chk_eq("a_rst_dout", dout, 32'h0);
        rst_a = 1'b0;
        busy_len("a_clear_len", 256);

        rd_chk("a_rd0",   8'd0,   32'h0, 1);
        rd_chk("a_rd128", 8'd128, 32'h0, 1);
        rd_chk("a_rd255", 8'd255, 32'h0, 1);

        wr(8'd5, 32'hAABBCCDD, 4'b1111);
        rd_chk("a_be_full", 8'd5, 32'hAABBCCDD, 1);
        wr(8'd5, 32'h11223344, 4'b0101);
        rd_chk("a_be_mix", 8'd5, 32'hAA22CC44, 1);
        wr(8'd5, 32'hFFFFFFFF, 4'b0000);
        rd_chk("a_be_none", 8'd5, 32'hAA22CC44, 1);

`ifdef SYNC_MEM_BYPASS_EN
        exp_col = 32'h12345678;
`else
        exp_col = 32'h00000000;
`endif
        // addr 9 holds zero from the clear; write a nonzero word elsewhere
        // first so the collision result is not the prior data_out
        wr(8'd7, 32'h5A5A5A5A, 4'hF);
        rd_chk("a_pre_col", 8'd7, 32'h5A5A5A5A, 1);
        we = 1'b1; wa = 8'd9; data_in = 32'h12345678; be = 4'hF;
        re = 1'b1; ra = 8'd9;
        step();
        we = 1'b0; re = 1'b0; be = 4'h0;
        chk_eq("a_col_vld", vld, 1'b1);
        chk_eq("a_col_dout", dout, exp_col);
        held = dout;
        step();
        chk_eq("a_hold_vld", vld, 1'b0);
        chk_eq("a_hold_dout", dout, held);
        step();
        chk_eq("a_hold_dout2", dout, held);
        rd_chk("a_after_col", 8'd9, 32'h12345678, 1);

        wr(8'd3, 32'h000000FF, 4'hF);
        rd_chk("a_pre_clr3", 8'd3, 32'h000000FF, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_eq("a_clr_busy", bsy, 1'b1);
        re = 1'b1; ra = 8'd3;
        n = 0; pulses = 0;
        while (bsy && n < 1000) begin
            clr = (n == 10);
            step();
            n++;
            if (vld) pulses++;
        end
        clr = 1'b0; re = 1'b0;
        chk_eq("a_clr_len", n, 256);
        chk_eq("a_clr_novld", pulses, 0);
        rd_chk("a_clr_rd3", 8'd3, 32'h0, 1);
        rd_chk("a_clr_rd5", 8'd5, 32'h0, 1);

        // ---------------- dut_b: DEPTH=200, latency 2 ----------------
        rst_a = 1'b1;
        sel = 1'b1;
        step();
        chk_eq("b_rst_busy", bsy, 1'b1);
        rst_b = 1'b0;
        busy_len("b_clear_len", 200);

        wr(8'd1, 32'h00000101, 4'hF);
        wr(8'd2, 32'h00000202, 4'hF);
        wr(8'd3, 32'h00000303, 4'hF);
        re = 1'b1; ra = 8'd1;
        step();
        chk_eq("b_lat_v0", vld, 1'b0);
        ra = 8'd2;
        step();
        chk_eq("b_lat_v1", vld, 1'b1);
        chk_eq("b_lat_d1", dout, 32'h101);
        ra = 8'd3;
        step();
        re = 1'b0;
        chk_eq("b_lat_v2", vld, 1'b1);
        chk_eq("b_lat_d2", dout, 32'h202);
        step();
        chk_eq("b_lat_v3", vld, 1'b1);
        chk_eq("b_lat_d3", dout, 32'h303);
        step();
        chk_eq("b_lat_v4", vld, 1'b0);
        chk_eq("b_lat_hold", dout, 32'h303);

        wr(8'd210, 32'hDEADBEEF, 4'hF);
        rd_chk("b_oor_rd", 8'd210, 32'h0, 2);

        for (int i = 0; i <= 200; i++) begin
            if (i < 200) begin
                re = 1'b1; ra = 8'(i);
            end else begin
                re = 1'b0;
            end
            step();
            if (i >= 1) begin
                chk_eq("b_sweep_v", vld, 1'b1);
                chk_eq("b_sweep_d", dout,
                       (i - 1 >= 1 && i - 1 <= 3) ? 32'(i - 1) * 32'h101 : 32'h0);
            end
        end

        rst_b = 1'b1;
        step();
        chk_eq("b_rst_dout", dout, 32'h0);
        chk_eq("b_rst_vld", vld, 1'b0);
        rst_b = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk_eq("b_mid_busy", bsy, 1'b1);
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        busy_len("b_restart_len", 200);
        rd_chk("b_post_rd2", 8'd2, 32'h0, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sync_memory_dp.md
SYNC_MEMORY_DP -- requirements
Module: sync_memory_dp

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the word width in bits, which must be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, the address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 256, the number of words, with 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter RD_LATENCY, default 1, the read latency in cycles; legal values are 1 or 2.
REQ-005 Port clk SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-007 Port data_in SHALL be an input, DATA_WIDTH bits: write data.
REQ-008 Port write_enable SHALL be an input, 1 bit: write request.
REQ-009 Port byte_en SHALL be an input, DATA_WIDTH/8 bits: per-byte write mask; bit i selects data_in[8i+7:8i].
REQ-010 Port wr_addr SHALL be an input, ADDR_WIDTH bits: write address.
REQ-011 Port read_enable SHALL be an input, 1 bit: read request.
REQ-012 Port rd_addr SHALL be an input, ADDR_WIDTH bits: read address.
REQ-013 Port clear_req SHALL be an input, 1 bit: single-cycle request to zero the whole array.
REQ-014 Port data_out SHALL be an output, DATA_WIDTH bits: registered read data.
REQ-015 Port rd_valid SHALL be an output, 1 bit: one-cycle pulse marking data_out as new.
REQ-016 Port busy SHALL be an output, 1 bit: high while a clear is in progress.

Function
REQ-017 The control FSM SHALL have exactly two states, CLEAR and READY; busy SHALL be 1 in CLEAR and 0 in READY.
REQ-018 In CLEAR, each cycle SHALL write all-zero to address clr_cnt and then increment clr_cnt; after the cycle that writes DEPTH-1, the FSM SHALL go to READY and clr_cnt SHALL return to 0.
REQ-019 A clear SHALL last exactly DEPTH cycles, and busy SHALL fall on the edge after the write of address DEPTH-1.
REQ-020 In READY, if write_enable=1 and wr_addr<DEPTH, each byte with byte_en=1 SHALL be written and each byte with byte_en=0 SHALL be preserved.
REQ-021 Writes with wr_addr>=DEPTH, or with byte_en all zero, SHALL leave the array unchanged.
REQ-022 In READY, read_enable=1 SHALL register memory[rd_addr]; data_out and rd_valid SHALL update exactly RD_LATENCY cycles after the accepting edge.
REQ-023 A read with rd_addr>=DEPTH SHALL return all-zero with rd_valid=1.
REQ-024 When RD_LATENCY=2, the read pipeline SHALL accept a new read every cycle; back-to-back reads SHALL produce back-to-back rd_valid pulses in issue order.
REQ-025 data_out SHALL hold its last value when no rd_valid pulse is output.
REQ-026 In CLEAR, write_enable and read_enable SHALL be ignored: no array change and no new rd_valid; reads already in the pipeline SHALL still complete.
REQ-027 clear_req=1 in READY SHALL still perform that cycle's read and write; the FSM SHALL enter CLEAR on the next edge.
REQ-028 clear_req=1 while in CLEAR SHALL be ignored and SHALL NOT restart the count.
REQ-029 For a same-cycle read and write to the same address, the read result SHALL follow the Configuration section.

Reset
REQ-030 rst=1 on a rising edge SHALL set the FSM to CLEAR, clr_cnt to 0, busy to 1, rd_valid to 0, data_out to all-zero, and flush the read pipeline.
REQ-031 Array contents SHALL NOT be reset directly; they SHALL become zero only through the CLEAR sequence that starts on the first edge with rst=0.
REQ-032 rst asserted mid-clear SHALL restart the clear from address 0.

Configuration
REQ-033 Macro SYNC_MEM_BYPASS_EN defined: a same-address read and write SHALL return the byte-merged new word (write-first).
REQ-034 Macro SYNC_MEM_BYPASS_EN undefined: a same-address read and write SHALL return the word as it was before the write (read-first).
REQ-035 All other behaviour SHALL be identical whether or not SYNC_MEM_BYPASS_EN is defined.

Verification
REQ-036 Reset then clear, DEPTH=256: release rst -> busy=1 for exactly 256 cycles; then reading addresses 0, 128 and 255 -> data_out=0x00000000 with rd_valid.
REQ-037 Byte enables: write 0xAABBCCDD to address 5 with byte_en=4'b1111, then 0x11223344 with byte_en=4'b0101 -> reading address 5 returns 0xAA22CC44.
REQ-038 Read latency, RD_LATENCY=2: reads of addresses 1, 2, 3 on consecutive cycles -> three consecutive rd_valid pulses starting 2 cycles after the first read, with data in order 1, 2, 3.
REQ-039 Collision: address 9 holds 0x0; in the same cycle write 0x12345678 to 9 and read 9 -> 0x12345678 with SYNC_MEM_BYPASS_EN defined, 0x00000000 without.
REQ-040 Clear mid-operation: write 0xFF to address 3, pulse clear_req, and issue read_enable during busy -> no rd_valid while busy; after busy falls, reading address 3 returns 0.
REQ-041 Out-of-range, DEPTH=200, ADDR_WIDTH=8: write 0xDEADBEEF to address 210 and then read address 210 -> data_out=0 and addresses 0..199 unchanged; rst asserted at clear count 100 -> busy lasts a full 200 cycles after release.
